n_recombine_6: RTL and testbench
================================

N_RECOMBINE_6 -- requirements
Module: N_recombine_6

Interface
REQ-001 Parameter SATURATE, default 1: on error, 1 drives stream_out_data to 7'd127; 0 drives the low 7 bits of the raw sum.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 stream_in_data  input  8  [7:3] quotient Q (0..31), [2:0] remainder R (valid range 0..5).
REQ-005 stream_in_startofpacket  input  1  marks the first beat of a packet.
REQ-006 stream_in_endofpacket  input  1  marks the last beat of a packet.
REQ-007 stream_in_valid  input  1  input beat present.
REQ-008 stream_in_ready  output  1  block can accept an input beat this cycle.
REQ-009 stream_out_data  output  7  reconstructed index N = Q*6 + R.
REQ-010 stream_out_error  output  1  beat flagged: R > 5, or Q*6+R > 127.
REQ-011 stream_out_startofpacket  output  1  forwarded SOP of the beat.
REQ-012 stream_out_endofpacket  output  1  forwarded EOP of the beat.
REQ-013 stream_out_valid  output  1  output beat present.
REQ-014 stream_out_ready  input  1  downstream accepts the beat this cycle.

Function
REQ-015 An input beat transfers when stream_in_valid and stream_in_ready are both 1 on a rising edge; an output beat transfers when stream_out_valid and stream_out_ready are both 1.
REQ-016 Two-stage register pipeline: S1 holds Q*4 + Q*2 (8 bits), R, SOP, EOP and the R>5 flag; S2 holds the 8-bit sum, the final error and the SOP/EOP; S2 drives all stream_out_* signals.
REQ-017 Latency: an accepted beat appears on stream_out_* exactly 2 cycles after acceptance when stream_out_ready stays 1.
REQ-018 Throughput: one beat per cycle sustained while stream_out_ready = 1.
REQ-019 S2 loads when S1 is valid and (S2 is empty or S2 transfers this cycle); S1 loads when an input beat transfers.
REQ-020 stream_in_ready = (S1 empty) or (S1 advances into S2 this cycle); combinational from stream_out_ready.
REQ-021 While stream_out_valid = 1 and stream_out_ready = 0, all stream_out_* signals hold stable and no beat is lost or duplicated.
REQ-022 Arithmetic: sum computed 8 bits wide with no truncation before the compare; error = (R > 5) or (sum > 127).
REQ-023 Error beat: stream_out_error = 1; stream_out_data = 7'd127 when SATURATE = 1, else sum[6:0]; the beat is still forwarded with its SOP/EOP.
REQ-024 Packet FSM with states IDLE and IN_PKT; reset enters IDLE.
REQ-025 IDLE: an accepted beat with SOP = 0 is consumed (ready honoured) and discarded; an accepted beat with SOP = 1 enters the pipeline and moves the FSM to IN_PKT, or stays in IDLE if EOP = 1 on the same beat.
REQ-026 IN_PKT: every accepted beat enters the pipeline; EOP = 1 returns the FSM to IDLE; SOP = 1 mid-packet is forwarded unchanged and the FSM stays in IN_PKT.
REQ-027 Discarded beats never set stream_out_valid and never stall acceptance.
REQ-028 Simultaneous S2 output transfer and S1->S2 load in the same cycle replaces S2 contents with no bubble.

Reset
REQ-029 While reset = 1: S1/S2 valid cleared, FSM = IDLE, stream_out_valid = 0, stream_out_data = 0, stream_out_error = 0, stream_out_startofpacket = 0, stream_out_endofpacket = 0, stream_in_ready = 0.
REQ-030 Reset asserted mid-packet or with beats in flight discards all in-flight beats; stream_in_ready = 1 on the first cycle after reset deasserts.

Verification
REQ-031 SOP+EOP beat Q=21, R=1, stream_out_ready = 1 -> 2 cycles later stream_out_data = 127, error = 0, SOP = 1, EOP = 1.
REQ-032 Q=21, R=2 (SATURATE = 1) -> data = 127, error = 1; same beat with SATURATE = 0 -> data = 0, error = 1.
REQ-033 Q=3, R=6 -> error = 1; Q=0, R=0 -> data = 0, error = 0.
REQ-034 Four-beat packet Q = 1,2,3,4, R = 0, with stream_out_ready low 3 cycles after the first output -> outputs 6, 12, 18, 24 in order; stream_out_* held during the stall; stream_in_ready = 0 once both stages are full.
REQ-035 Two beats without SOP in IDLE, then SOP beat Q=5, R=5 -> only data = 35 is output; both earlier beats are consumed.
REQ-036 Reset pulsed 1 cycle with 2 beats in flight -> no output beats afterward; FSM = IDLE; next SOP beat Q=2, R=3 -> data = 15.

Source files
------------

// File: rtl/n_recombine_6.sv
// n_recombine_6: rebuilds an index N = Q*6 + R from a packed quotient and
// remainder, passing it through a two-stage valid/ready pipeline.
//
// Ports:
//   clk                      - single clock, rising-edge active
//   reset                    - synchronous active-high reset
//   stream_in_data[7:0]      - [7:3] quotient Q, [2:0] remainder R
//   stream_in_startofpacket  - first beat of a packet
//   stream_in_endofpacket    - last beat of a packet
//   stream_in_valid          - input beat present
//   stream_in_ready          - input beat can be accepted this cycle
//   stream_out_data[6:0]     - reconstructed index (or saturated on error)
//   stream_out_error         - R > 5 or Q*6+R > 127
//   stream_out_startofpacket - forwarded SOP
//   stream_out_endofpacket   - forwarded EOP
//   stream_out_valid         - output beat present
//   stream_out_ready         - downstream accepts the beat this cycle
//
// Parameter SATURATE: nonzero forces error beats to 7'd127, zero passes the
// low 7 bits of the raw sum.
module n_recombine_6 #(
  parameter int unsigned SATURATE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] stream_in_data,
  input  logic       stream_in_startofpacket,
  input  logic       stream_in_endofpacket,
  input  logic       stream_in_valid,
  output logic       stream_in_ready,
  output logic [6:0] stream_out_data,
  output logic       stream_out_error,
  output logic       stream_out_startofpacket,
  output logic       stream_out_endofpacket,
  output logic       stream_out_valid,
  input  logic       stream_out_ready
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IN_PKT = 1'b1;

  logic [0:0] state;

  // Stage 1: partial product Q*6 plus remainder and flags
  logic       s1_valid;
  logic [7:0] s1_q6;
  logic [2:0] s1_r;
  logic       s1_rerr;
  logic       s1_sop;
  logic       s1_eop;

  // Stage 2: final result, drives the output stream
  logic       s2_valid;
  logic [6:0] s2_data;
  logic       s2_err;
  logic       s2_sop;
  logic       s2_eop;

  logic [4:0] in_q;
  logic [2:0] in_r;
  logic [7:0] in_q6;
  logic [7:0] s1_sum;
  logic       s1_err;
  logic       s1_adv;
  logic       in_xfer;
  logic       in_keep;

  always_comb begin
    in_q  = stream_in_data[7:3];
    in_r  = stream_in_data[2:0];
    in_q6 = {1'b0, in_q, 2'b00} + {2'b00, in_q, 1'b0};

    // Q <= 31 and R <= 7 keep the sum below 256, so bit 7 never wraps
    s1_sum = s1_q6 + {5'b0, s1_r};
    s1_err = s1_rerr | (s1_sum > 8'd127);

    s1_adv          = s1_valid & (~s2_valid | stream_out_ready);
    stream_in_ready = ~reset & (~s1_valid | s1_adv);
    in_xfer         = stream_in_valid & stream_in_ready;
    // Beats outside a packet are accepted but dropped before stage 1
    in_keep         = in_xfer & ((state == IN_PKT) | stream_in_startofpacket);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (in_xfer) begin
      if (state == IDLE) begin
        if (stream_in_startofpacket && !stream_in_endofpacket) state <= IN_PKT;
      end else if (stream_in_endofpacket) begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_q6    <= '0;
      s1_r     <= '0;
      s1_rerr  <= 1'b0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
    end else if (in_keep) begin
      s1_valid <= 1'b1;
      s1_q6    <= in_q6;
      s1_r     <= in_r;
      s1_rerr  <= (in_r > 3'd5);
      s1_sop   <= stream_in_startofpacket;
      s1_eop   <= stream_in_endofpacket;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_err   <= 1'b0;
      s2_sop   <= 1'b0;
      s2_eop   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_data  <= (s1_err && SATURATE != 0) ? 7'd127 : s1_sum[6:0];
      s2_err   <= s1_err;
      s2_sop   <= s1_sop;
      s2_eop   <= s1_eop;
    end else if (s2_valid && stream_out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign stream_out_valid         = s2_valid;
  assign stream_out_data          = s2_data;
  assign stream_out_error         = s2_err;
  assign stream_out_startofpacket = s2_sop;
  assign stream_out_endofpacket   = s2_eop;

endmodule

// File: tb/tb_n_recombine_6.sv
// Directed testbench for n_recombine_6. A second instance with SATURATE = 0
// shares the inputs so the non-saturating error data can be observed.
module tb_n_recombine_6;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_sop, in_eop, in_valid;
  logic       in_ready;
  logic [6:0] out_data;
  logic       out_err, out_sop, out_eop, out_valid;
  logic       out_ready;

  logic       in_ready0;
  logic [6:0] out_data0;
  logic       out_err0, out_sop0, out_eop0, out_valid0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  n_recombine_6 dut (
    .clk(clk), .reset(reset),
    .stream_in_data(in_data), .stream_in_startofpacket(in_sop),
    .stream_in_endofpacket(in_eop), .stream_in_valid(in_valid),
    .stream_in_ready(in_ready),
    .stream_out_data(out_data), .stream_out_error(out_err),
    .stream_out_startofpacket(out_sop), .stream_out_endofpacket(out_eop),
    .stream_out_valid(out_valid), .stream_out_ready(out_ready)
  );

  n_recombine_6 #(.SATURATE(0)) dut0 (
    .clk(clk), .reset(reset),
    .stream_in_data(in_data), .stream_in_startofpacket(in_sop),
    .stream_in_endofpacket(in_eop), .stream_in_valid(in_valid),
    .stream_in_ready(in_ready0),
    .stream_out_data(out_data0), .stream_out_error(out_err0),
    .stream_out_startofpacket(out_sop0), .stream_out_endofpacket(out_eop0),
    .stream_out_valid(out_valid0), .stream_out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int q, input int r, input logic sop, input logic eop);
    logic [4:0] qq;
    logic [2:0] rr;
    qq = q[4:0];
    rr = r[2:0];
    in_data  = {qq, rr};
    in_sop   = sop;
    in_eop   = eop;
    in_valid = 1'b1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    put(9, 1, 1'b1, 1'b0);
    tick();
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", out_valid); end
    tests++; if (out_data !== 7'd0) begin fails++; $display("FAIL rst_data got %0d want 0", out_data); end
    tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", out_err); end
    tests++; if ({out_sop, out_eop} !== 2'b00) begin fails++; $display("FAIL rst_sopeop got %b want 00", {out_sop, out_eop}); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    idle_in();
    reset = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    put(21, 1, 1'b1, 1'b1);
    tick();
    idle_in();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_lat1 got valid %b want 0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", out_valid); end
    tests++; if (out_data !== 7'd127) begin fails++; $display("FAIL basic_data got %0d want 127", out_data); end
    tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL basic_err got %b want 0", out_err); end
    tests++; if ({out_sop, out_eop} !== 2'b11) begin fails++; $display("FAIL basic_sopeop got %b want 11", {out_sop, out_eop}); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain got valid %b want 0", out_valid); end
  endtask

  // Three single-beat packets back to back: one output per cycle
  task automatic test_back_to_back_errors();
    out_ready = 1'b1;
    put(21, 2, 1'b1, 1'b1);
    tick();
    put(3, 6, 1'b1, 1'b1);
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ovf_valid got %b want 1", out_valid); end
    tests++; if (out_data !== 7'd127) begin fails++; $display("FAIL ovf_data_sat got %0d want 127", out_data); end
    tests++; if (out_err !== 1'b1) begin fails++; $display("FAIL ovf_err got %b want 1", out_err); end
    tests++; if (out_data0 !== 7'd0) begin fails++; $display("FAIL ovf_data_nosat got %0d want 0", out_data0); end
    tests++; if (out_err0 !== 1'b1) begin fails++; $display("FAIL ovf_err_nosat got %b want 1", out_err0); end
    put(0, 0, 1'b1, 1'b1);
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rerr_valid got %b want 1", out_valid); end
    tests++; if (out_err !== 1'b1) begin fails++; $display("FAIL rerr_err got %b want 1", out_err); end
    tests++; if (out_data !== 7'd127) begin fails++; $display("FAIL rerr_data_sat got %0d want 127", out_data); end
    tests++; if (out_data0 !== 7'd24) begin fails++; $display("FAIL rerr_data_nosat got %0d want 24", out_data0); end
    idle_in();
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL zero_valid got %b want 1", out_valid); end
    tests++; if (out_data !== 7'd0) begin fails++; $display("FAIL zero_data got %0d want 0", out_data); end
    tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL zero_err got %b want 0", out_err); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got valid %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    put(1, 0, 1'b1, 1'b0);
    tick();
    put(2, 0, 1'b0, 1'b0);
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 7'd6) begin fails++; $display("FAIL stall_first got v%b %0d want v1 6", out_valid, out_data); end
    out_ready = 1'b0;
    put(3, 0, 1'b0, 1'b0);
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 7'd6 || out_sop !== 1'b1 || out_eop !== 1'b0 || out_err !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold%0d got v%b d%0d s%b e%b err%b want v1 d6 s1 e0 err0", i, out_valid, out_data, out_sop, out_eop, out_err);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_resume_ready got %b want 1", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 7'd12 || out_sop !== 1'b0) begin fails++; $display("FAIL stall_second got v%b d%0d s%b want v1 12 s0", out_valid, out_data, out_sop); end
    put(4, 0, 1'b0, 1'b1);
    tick();
    idle_in();
    tests++; if (out_valid !== 1'b1 || out_data !== 7'd18) begin fails++; $display("FAIL stall_third got v%b %0d want v1 18", out_valid, out_data); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 7'd24 || out_eop !== 1'b1) begin fails++; $display("FAIL stall_fourth got v%b d%0d e%b want v1 24 e1", out_valid, out_data, out_eop); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_drain got valid %b want 0", out_valid); end
  endtask

  task automatic test_discard();
    out_ready = 1'b1;
    put(1, 1, 1'b0, 1'b0);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL disc_ready1 got %b want 1", in_ready); end
    tick();
    put(2, 2, 1'b0, 1'b1);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL disc_ready2 got %b want 1", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL disc_out1 got valid %b want 0", out_valid); end
    put(5, 5, 1'b1, 1'b1);
    tick();
    idle_in();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL disc_out2 got valid %b want 0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 7'd35 || out_err !== 1'b0) begin fails++; $display("FAIL disc_data got v%b d%0d err%b want v1 35 err0", out_valid, out_data, out_err); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL disc_drain got valid %b want 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    put(1, 0, 1'b1, 1'b0);
    tick();
    put(2, 0, 1'b0, 1'b0);
    tick();
    idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mrst_ready got %b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_flush%0d got valid %b want 0", i, out_valid); end
    end
    // A non-SOP beat must be dropped, proving the FSM is back in IDLE
    put(7, 0, 1'b0, 1'b0);
    tick();
    put(2, 3, 1'b1, 1'b1);
    tick();
    idle_in();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_idle got valid %b want 0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 7'd15) begin fails++; $display("FAIL mrst_data got v%b %0d want v1 15", out_valid, out_data); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_drain got valid %b want 0", out_valid); end
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back_errors();
    test_stall();
    test_discard();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
